// File: rtl/mem_access_if.sv
// CPU-side request/response and RAM-side signals of the data-memory initiator.
// The slave modport belongs to mem_access_unit; master is the pipeline plus the RAM.
// The RAM reads asynchronously: ram_dout follows ram_addr in the same cycle.
interface mem_access_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) ();
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic              ram_ena;
  logic              ram_wena;
  logic [DEPTH-1:0]  ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  modport slave (
    input  req, we, size, sext, addr, wdata, ram_dout,
    output ready, done, err, rdata, ram_ena, ram_wena, ram_addr, ram_din
  );

  modport master (
    output req, we, size, sext, addr, wdata, ram_dout,
    input  ready, done, err, rdata, ram_ena, ram_wena, ram_addr, ram_din
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide async-read RAM; sub-word stores use read-modify-write.
// Latency (request cycle to done): error 1, load 2, word store 2, byte/half store 3.
// Backpressure: ready is low while an access is in flight; req is ignored then.
module mem_access_unit #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_access_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t           state_q, state_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             sext_q, sext_d;
  logic [DEPTH+1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      buf_q, buf_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             ram_ena_q, ram_ena_d;
  logic             ram_wena_q, ram_wena_d;

  logic [4:0]       lane_sh;
  logic [31:0]      rd_shift;
  logic [31:0]      ld_val;
  logic [31:0]      st_mask;
  logic [31:0]      st_data;
  logic             bad_req;

  // Upper address bits are outside the RAM and simply wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[ADDR_W-1:DEPTH+2];

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rdata    = rdata_q;
  assign bus.ram_ena  = ram_ena_q;
  assign bus.ram_wena = ram_wena_q;
  assign bus.ram_addr = addr_q[DEPTH+1:2];
  assign bus.ram_din  = buf_q;

  // Next-state, lane extraction/merge and registered-output computation.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    sext_d   = sext_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    buf_d    = buf_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    // Byte lane offset, or half lane offset rounded to 16 bits.
    lane_sh  = (size_q == 2'b00) ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
    rd_shift = bus.ram_dout >> lane_sh;
    case (size_q)
      2'b00:   ld_val = {{24{sext_q & rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   ld_val = {{16{sext_q & rd_shift[15]}}, rd_shift[15:0]};
      default: ld_val = bus.ram_dout;
    endcase
    st_mask  = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
    st_data  = ((size_q == 2'b00) ? {24'h0, wdata_q[7:0]} : {16'h0, wdata_q[15:0]}) << lane_sh;

    bad_req  = (bus.size == 2'b11) ||
               (bus.size == 2'b01 && bus.addr[0]) ||
               (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          size_d  = bus.size;
          sext_d  = bus.sext;
          addr_d  = bus.addr[DEPTH+1:0];
          wdata_d = bus.wdata;
          if (bad_req) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (bus.we && bus.size == 2'b10) begin
            buf_d   = bus.wdata;
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (we_q) begin
          buf_d   = (bus.ram_dout & ~st_mask) | (st_data & st_mask);
          state_d = S_WR;
        end else begin
          rdata_d = ld_val;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    ready_d    = (state_d == S_IDLE);
    ram_ena_d  = (state_d != S_IDLE);
    ram_wena_d = (state_d == S_WR);
  end

  // State and output registers; reset aborts any access before its write edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      sext_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      buf_q      <= 32'h0;
      rdata_q    <= 32'h0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
      ram_ena_q  <= 1'b0;
      ram_wena_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      ram_ena_q  <= ram_ena_d;
      ram_wena_q <= ram_wena_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a bench-side async-read RAM.
// Expected responses are computed from a word-array memory model at issue time.
// A negedge monitor pops and compares on every done/err pulse.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_if #(.DEPTH(8), .ADDR_W(32)) mif ();

  mem_access_unit #(.DEPTH(8), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif.slave)
  );

  // Bench RAM: asynchronous read, synchronous write.
  logic [31:0] ram [0:255];
  assign mif.ram_dout = ram[mif.ram_addr];
  always @(posedge clk) if (mif.ram_ena && mif.ram_wena) ram[mif.ram_addr] <= mif.ram_din;

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          edges;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [0:255];
  logic [31:0] exp_rdata = 32'h0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: applies the access to ref_mem and returns the expected response.
  task automatic model(input bit w, input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    int idx;
    int off;
    logic [31:0] word;
    logic [31:0] v;
    idx  = int'(a[9:2]);
    off  = int'(a[1:0]);
    word = ref_mem[idx];
    e.err   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    e.edges = 0;
    e.acc   = 0;
    if (!e.err) begin
      if (w) begin
        if (sz == 2'd0)
          word = (word & ~(32'hFF << (8 * off))) | ((wd & 32'hFF) << (8 * off));
        else if (sz == 2'd1)
          word = (word & ~(32'hFFFF << (16 * (off / 2)))) | ((wd & 32'hFFFF) << (16 * (off / 2)));
        else
          word = wd;
        ref_mem[idx] = word;
        e.edges = (sz == 2'd2) ? 1 : 2;
      end else begin
        if (sz == 2'd0) begin
          v = (word >> (8 * off)) & 32'hFF;
          if (sx && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'd1) begin
          v = (word >> (16 * (off / 2))) & 32'hFFFF;
          if (sx && v >= 32'd32768) v = v - 32'd65536;
        end else begin
          v = word;
        end
        exp_rdata = v;
        e.edges = 1;
      end
    end
    e.rdata = exp_rdata;
  endtask

  task automatic issue(input bit w, input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!mif.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!mif.ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: ready stayed 0 for %0d cycles, required 1", n);
      return;
    end
    mif.req = 1'b1; mif.we = w; mif.size = sz; mif.sext = sx; mif.addr = a; mif.wdata = wd;
    model(w, sz, sx, a, wd, e);
    @(posedge clk);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    mif.req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !mif.ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mif.err && !mif.done) chk("err_without_done", 32'(mif.err), 32'(mif.done));
      if (mif.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 with no request outstanding, required 0");
        end else begin
          e = sb.pop_front();
          chk("err", 32'(mif.err), 32'(e.err));
          chk("rdata", mif.rdata, e.rdata);
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.edges + 1));
          if (mif.err) chk("err_no_ram", 32'(mif.ram_ena), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [31:0] v;
    exp_t e;
    int prev;
    int acc;
    int guard;
    mif.req = 1'b0; mif.we = 1'b0; mif.size = 2'd0; mif.sext = 1'b0;
    mif.addr = 32'h0; mif.wdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      ram[i] <= v;
      ref_mem[i] = v;
    end
    #12;
    chk("rst_ready", 32'(mif.ready), 32'd1);
    chk("rst_done", 32'(mif.done), 32'd0);
    chk("rst_err", 32'(mif.err), 32'd0);
    chk("rst_rdata", mif.rdata, 32'h0);
    chk("rst_ram_ena", 32'(mif.ram_ena), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed sequences.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h123456AA);
    issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h12, 32'hFFFF1234);
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    issue(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
    drain();
    chk("word_0x10", ram[4], 32'h1234AAEF);
    chk("lh_sext_0x10", mif.rdata, 32'hFFFFAAEF);
    issue(1'b0, 2'd2, 1'b0, 32'h13, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h11, 32'h5555);
    issue(1'b1, 2'd3, 1'b0, 32'h10, 32'h7777);
    drain();
    chk("err_keeps_rdata", mif.rdata, 32'hFFFFAAEF);
    chk("err_keeps_word", ram[4], 32'h1234AAEF);

    // Randomized traffic with occasional idle gaps and random upper address bits.
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63)), $urandom);
    end
    drain();

    // req held high: only idle cycles accept, toggles while busy are ignored.
    @(negedge clk);
    mif.we = 1'b0; mif.size = 2'd2; mif.sext = 1'b0; mif.addr = 32'h10;
    prev = -1; acc = 0; guard = 0;
    while (acc < 4 && guard < 40) begin
      if (mif.ready) begin
        mif.req = 1'b1;
        model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e);
        @(posedge clk);
        #1;
        e.acc = cyc;
        sb.push_back(e);
        if (prev >= 0) chk("b2b_spacing", 32'(cyc - prev), 32'd2);
        prev = cyc;
        acc++;
      end else begin
        mif.req = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      guard++;
    end
    mif.req = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd4);
    drain();

    // Reset in the read phase of a byte store: no write, outputs back to reset values.
    @(negedge clk);
    mif.req = 1'b1; mif.we = 1'b1; mif.size = 2'd0; mif.sext = 1'b0;
    mif.addr = 32'h21; mif.wdata = 32'h55;
    @(posedge clk);
    #1;
    mif.req = 1'b0;
    @(negedge clk);
    chk("rd_phase_ena", 32'(mif.ram_ena), 32'd1);
    chk("rd_phase_wena", 32'(mif.ram_wena), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(mif.ready), 32'd1);
    chk("arst_done", 32'(mif.done), 32'd0);
    chk("arst_err", 32'(mif.err), 32'd0);
    chk("arst_rdata", mif.rdata, 32'h0);
    chk("arst_ram_ena", 32'(mif.ram_ena), 32'd0);
    chk("arst_ram_addr", 32'(mif.ram_addr), 32'h0);
    chk("arst_ram_din", mif.ram_din, 32'h0);
    exp_rdata = 32'h0;
    repeat (2) begin
      @(negedge clk);
      chk("arst_wena", 32'(mif.ram_wena), 32'd0);
    end
    rst_n = 1'b1;
    chk("arst_word", ram[8], ref_mem[8]);
    issue(1'b0, 2'd0, 1'b0, 32'h21, 32'h0);
    drain();

    for (int i = 0; i < 256; i++) chk($sformatf("mem[%0d]", i), ram[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
